// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned WAIT_CNT_W = 16;
   localparam int unsigned CNT_W      = 3;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      FLUSH      = 2'd2,
      MEM_WAIT   = 2'd3
   } ctrl_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detect: instruction in ID reads the rd of a load sitting in EX.
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic                  if_id_valid,
   input  logic [REG_ADDR_W-1:0] if_id_rs1,
   input  logic [REG_ADDR_W-1:0] if_id_rs2,
   input  logic [REG_ADDR_W-1:0] id_ex_rd,
   input  logic                  id_ex_memread,
   output logic                  hazard_c
);

   // x0 is never a real destination, so a load targeting it cannot create a hazard
   assign hazard_c = if_id_valid && id_ex_memread && (id_ex_rd != '0) &&
                     ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, branch redirect
// and data-memory wait into pipeline-register enables, plus error flag and perf counters.
module pipeline_stall_controller
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned FETCH_LATENCY = 1,
   parameter int unsigned MEM_TIMEOUT   = 255,
   parameter int unsigned PERF_W        = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_id_valid,
   input  logic [REG_ADDR_W-1:0] if_id_rs1,
   input  logic [REG_ADDR_W-1:0] if_id_rs2,
   input  logic [REG_ADDR_W-1:0] id_ex_rd,
   input  logic                  id_ex_memread,
   input  logic                  branch_taken,
   input  logic                  dmem_req,
   input  logic                  dmem_ready,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  if_id_flush,
   output logic                  id_ex_bubble,
   output logic                  pipe_freeze,
   output logic [1:0]            ctrl_state,
   output logic                  mem_timeout_err,
   output logic [PERF_W-1:0]     stall_cycles,
   output logic [PERF_W-1:0]     flush_cycles
);

   localparam int unsigned WAIT_EXT_W = WAIT_CNT_W + 1;
   // FLUSH cycles owed after the taken cycle; zero means the taken cycle alone covers it
   localparam logic [CNT_W-1:0]      FLUSH_RELOAD = CNT_W'(FETCH_LATENCY - 1);
   localparam logic [WAIT_EXT_W-1:0] TIMEOUT_LIM  = WAIT_EXT_W'(MEM_TIMEOUT);
   localparam logic [PERF_W-1:0]     PERF_MAX     = {PERF_W{1'b1}};

   ctrl_state_t           state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_dec;
   logic [WAIT_CNT_W-1:0] wait_q, wait_d;
   logic                  err_set_c;
   logic                  hz_c;
   logic                  mw_c;

   load_use_detect u_load_use_detect (
      .if_id_valid   (if_id_valid),
      .if_id_rs1     (if_id_rs1),
      .if_id_rs2     (if_id_rs2),
      .id_ex_rd      (id_ex_rd),
      .id_ex_memread (id_ex_memread),
      .hazard_c      (hz_c)
   );

   assign mw_c       = dmem_req && !dmem_ready;
   assign ctrl_state = state_q;

   // Next state: memory wait beats branch, branch beats load-use
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wait_d    = wait_q;
      err_set_c = 1'b0;
      cnt_dec   = cnt_q - CNT_W'(1);
      if (state_q == MEM_WAIT) begin
         if (!mw_c) begin
            state_d = RUN;
         end else if ((WAIT_EXT_W'(wait_q) + WAIT_EXT_W'(1)) >= TIMEOUT_LIM) begin
            state_d   = RUN;
            err_set_c = 1'b1;
         end else begin
            wait_d = wait_q + WAIT_CNT_W'(1);
         end
      end else if (mw_c) begin
         state_d = MEM_WAIT;
         wait_d  = '0;
      end else if (branch_taken) begin
         cnt_d   = FLUSH_RELOAD;
         state_d = (FLUSH_RELOAD != '0) ? FLUSH : RUN;
      end else if (state_q == FLUSH) begin
         cnt_d = cnt_dec;
         if (cnt_dec == '0) begin
            state_d = RUN;
         end
      end else if ((state_q == RUN) && hz_c) begin
         state_d = LOAD_STALL;
      end else begin
         state_d = RUN;
      end
   end

   // Mealy control outputs for the event that wins this cycle
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      pipe_freeze  = 1'b0;
      if (reset) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (mw_c) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         pipe_freeze = 1'b1;
      end else if (branch_taken && (state_q != MEM_WAIT)) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (state_q == FLUSH) begin
         if_id_write  = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if ((state_q == RUN) && hz_c) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= RUN;
         cnt_q           <= '0;
         wait_q          <= '0;
         mem_timeout_err <= 1'b0;
         stall_cycles    <= '0;
         flush_cycles    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wait_q  <= wait_d;
         if (err_set_c) begin
            mem_timeout_err <= 1'b1;
         end
         if (!pc_write && (stall_cycles != PERF_MAX)) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
         end
         if (if_id_flush && (flush_cycles != PERF_MAX)) begin
            flush_cycles <= flush_cycles + PERF_W'(1);
         end
      end
   end

endmodule
